// File: rtl/array_index_pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : array_index_pipeline_pkg
// Description : Shared helpers for the array-index pipeline: index width,
//               bounds predicate and stage-payload width. The stage payload
//               is laid out as {data[ELEM_W-1:0], oob}, data in the upper bits.
// Revision    : 1.0 - initial release
// ============================================================================
package array_index_pipeline_pkg;

    // One extra bit over the selector so that sel + OFFSET cannot wrap.
    function automatic int idx_width(input int sel_w);
        return sel_w + 1;
    endfunction

    // True when an index addresses a real element of the array.
    function automatic logic in_bounds(input int idx, input int num_elems);
        return (idx < num_elems);
    endfunction

    // Width of one stage payload: element data plus the out-of-bounds flag.
    function automatic int payload_width(input int elem_w);
        return elem_w + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/array_index_pipeline_slice.sv
`default_nettype none
// ============================================================================
// Module      : array_index_pipeline_slice
// Description : One valid/ready register slice. Loads whenever it is empty or
//               its consumer is ready, so an empty slice absorbs data even while
//               everything downstream is stalled.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               i_valid/o_ready  - upstream handshake (o_ready is combinational)
//               i_data           - upstream payload
//               o_valid/i_ready  - downstream handshake
//               o_data           - registered payload
// Revision    : 1.0 - initial release
// ============================================================================
module array_index_pipeline_slice
    import array_index_pipeline_pkg::*;
#(
    parameter int DATA_W = 33
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              w_ready;

    assign w_ready = !r_valid || i_ready;
    assign o_ready = w_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_ready) begin
            r_valid <= i_valid;
            // Payload only moves with a real transaction; it holds otherwise.
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/array_index_pipeline.sv
`default_nettype none
// ============================================================================
// Module      : array_index_pipeline
// Description : Stall-capable pipeline selecting element (sel + OFFSET) from a
//               flattened array. Stage 1 registers the request, stage 2 does
//               the select, stages 3..STAGES are plain register slices.
//               Optional feature macro ARRAY_INDEX_PIPELINE_BOUNDS_CHECK_EN:
//               out-of-bounds indices clamp to the last element and raise
//               out_oob. Without it out_oob is constant 0.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               in_valid/in_ready     - request handshake
//               in_sel, in_arr        - selector and flattened array
//               out_valid/out_ready   - result handshake
//               out_data, out_oob     - selected element, out-of-bounds flag
// Revision    : 1.0 - initial release
// ============================================================================
module array_index_pipeline
    import array_index_pipeline_pkg::*;
#(
    parameter int ELEM_W    = 32,
    parameter int NUM_ELEMS = 4,
    parameter int SEL_W     = 2,
    parameter int OFFSET    = 1,
    parameter int STAGES    = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SEL_W-1:0]            in_sel,
    input  logic [NUM_ELEMS*ELEM_W-1:0] in_arr,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ELEM_W-1:0]           out_data,
    output logic                        out_oob
);

    localparam int c_IDX_W = idx_width(SEL_W);
    localparam int c_PL_W  = payload_width(ELEM_W);

    typedef struct packed {
        logic [ELEM_W-1:0] data;
        logic              oob;
    } payload_t;

    // Ready/valid/payload per stage; w_rdy[STAGES+1] is the consumer's ready.
    logic     w_rdy      [2:STAGES+1];
    logic     w_pl_valid [2:STAGES];
    payload_t w_pl       [2:STAGES];

    // ---------------------------------------------------------------- stage 1
    logic                        r_s1_valid;
    logic [SEL_W-1:0]            r_s1_sel;
    logic [NUM_ELEMS*ELEM_W-1:0] r_s1_arr;
    logic                        w_s1_ready;

    assign w_s1_ready = !r_s1_valid || w_rdy[2];
    assign in_ready   = w_s1_ready && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sel   <= '0;
            r_s1_arr   <= '0;
        end else if (w_s1_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sel <= in_sel;
                r_s1_arr <= in_arr;
            end
        end
    end

    // ---------------------------------------------------------------- stage 2
    logic [c_IDX_W-1:0] w_idx;
    logic [ELEM_W-1:0]  w_sel_data;
    logic               w_oob;
    logic               r_s2_valid;
    payload_t           r_s2_pl;

    assign w_idx = {1'b0, r_s1_sel} + c_IDX_W'(OFFSET);

    always_comb begin
        w_sel_data = '0;
        w_oob      = 1'b0;
        for (int k = 0; k < NUM_ELEMS; k++) begin
            if (int'(w_idx) == k) begin
                w_sel_data = r_s1_arr[k*ELEM_W +: ELEM_W];
            end
        end
`ifdef ARRAY_INDEX_PIPELINE_BOUNDS_CHECK_EN
        if (!in_bounds(int'(w_idx), NUM_ELEMS)) begin
            w_oob      = 1'b1;
            w_sel_data = r_s1_arr[(NUM_ELEMS-1)*ELEM_W +: ELEM_W];
        end
`endif
    end

    assign w_rdy[2] = !r_s2_valid || w_rdy[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_pl    <= '0;
        end else if (w_rdy[2]) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_pl <= '{data: w_sel_data, oob: w_oob};
            end
        end
    end

    assign w_pl_valid[2] = r_s2_valid;
    assign w_pl[2]       = r_s2_pl;

    // --------------------------------------------------------- stages 3..N
    for (genvar i = 3; i <= STAGES; i++) begin : g_slice
        array_index_pipeline_slice #(
            .DATA_W (c_PL_W)
        ) u_slice (
            .clk     (clk),
            .rst     (rst),
            .i_valid (w_pl_valid[i-1]),
            .o_ready (w_rdy[i]),
            .i_data  (w_pl[i-1]),
            .o_valid (w_pl_valid[i]),
            .i_ready (w_rdy[i+1]),
            .o_data  (w_pl[i])
        );
    end

    // ----------------------------------------------------------------- output
    assign w_rdy[STAGES+1] = out_ready;
    assign out_valid       = w_pl_valid[STAGES];
    assign out_data        = w_pl[STAGES].data;
    assign out_oob         = w_pl[STAGES].oob;

endmodule
`default_nettype wire
